// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side drain adapter for async_fifo, clocked in the read domain.
//   Turns the FIFO's rd_en / empty / registered rd_data interface into a
//   valid/ready stream. A 2-entry prefetch buffer sustains one word per cycle
//   and absorbs back-pressure without losing or duplicating words. Also counts
//   delivered words and supports a synchronous flush.
//
// Ports
//   rd_clk      in   1      read-domain clock, all logic on posedge
//   rd_rst_n    in   1      asynchronous active-low reset
//   fifo_empty  in   1      async_fifo empty flag
//   fifo_rd_en  out  1      pop request to async_fifo
//   fifo_rdata  in   DW     async_fifo rd_data, valid 1 cycle after a pop
//   flush       in   1      drop buffered and in-flight words
//   m_valid     out  1      output word valid
//   m_ready     in   1      downstream accept
//   m_data      out  DW     output word (buffer head)
//   word_cnt    out  CNT_W  words accepted downstream, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DW-1:0]    fifo_rdata,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [CNT_W-1:0] word_cnt
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_inflight;
  logic             r_head;
  logic             r_tail;
  logic [DW-1:0]    r_buf [2];
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_pop;
  logic             w_cap;
  logic [2:0]       w_occ;

  assign w_pop = (r_state != S_EMPTY) & m_ready;
  // A word returning during a flush cycle is discarded, never written.
  assign w_cap = r_inflight & ~flush;
  // Words owned by the adapter after this cycle's pop; a new request is only
  // issued when its data is guaranteed a free slot on arrival.
  assign w_occ = {1'b0, r_state} + {2'b00, r_inflight} - {2'b00, w_pop};

  // ---- state register ----
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case ({w_cap, w_pop})
        2'b10: begin
          case (r_state)
            S_EMPTY: w_state_nxt = S_ONE;
            S_ONE:   w_state_nxt = S_FULL;
            default: w_state_nxt = S_FULL;
          endcase
        end
        2'b01: begin
          case (r_state)
            S_FULL:  w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
          endcase
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // ---- output logic ----
  always_comb begin
    m_valid    = (r_state != S_EMPTY);
    fifo_rd_en = rd_rst_n & ~fifo_empty & ~flush & (w_occ < 3'd2);
  end

  // ---- datapath: in-flight flag, pointers, buffer, counter ----
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (flush) begin
        r_head <= 1'b0;
        r_tail <= 1'b0;
      end else begin
        if (w_pop) begin
          r_head     <= ~r_head;
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
        if (w_cap) begin
          r_buf[r_tail] <= fifo_rdata;
          r_tail        <= ~r_tail;
        end
      end
    end
  end

  assign m_data   = r_buf[r_head];
  assign word_cnt = r_word_cnt;

  // The issue rule keeps a returning word from ever meeting a full buffer.
  a_no_cap_when_full: assert property (
    @(posedge rd_clk) disable iff (!rd_rst_n) !(w_cap && r_state == S_FULL)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             rd_clk     = 1'b0;
  logic             rd_rst_n   = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_rdata = '0;
  logic             flush      = 1'b0;
  logic             m_valid;
  logic             m_ready    = 1'b0;
  logic [DW-1:0]    m_data;
  logic [CNT_W-1:0] word_cnt;

  fifo_rd_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .rd_clk     (rd_clk),
    .rd_rst_n   (rd_rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt)
  );

  always #7 rd_clk = ~rd_clk;

  // Upstream FIFO model: writes staged in wq become visible at the next edge;
  // a pop sampled at an edge returns its word on fifo_rdata after that edge.
  logic [DW-1:0]    wq[$];
  logic [DW-1:0]    fq[$];
  // Scoreboard: every written word in order, minus what flush/reset discards.
  logic [DW-1:0]    exp_q[$];
  logic [DW-1:0]    e_data;
  logic [CNT_W-1:0] model_cnt = '0;
  logic             will_pop  = 1'b0;
  int               popped    = 0;
  int               delivered = 0;
  int               last_lost = 0;
  int               checks    = 0;
  int               errors    = 0;

  always @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      fq.delete();
      wq.delete();
      popped     = 0;
      fifo_empty <= 1'b1;
    end else begin
      if (will_pop) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL pop_when_empty: rd_en issued with fifo size 0, required size >= 1");
        end else begin
          fifo_rdata <= fq.pop_front();
          popped++;
        end
      end
      while (wq.size() != 0) fq.push_back(wq.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Monitor: everything sampled mid-cycle, i.e. what the next edge will see.
  always @(negedge rd_clk) begin
    if (!rd_rst_n) begin
      exp_q.delete();
      delivered = 0;
      model_cnt = '0;
      will_pop  = 1'b0;
    end else begin
      will_pop = fifo_rd_en;
      checks++;
      if (word_cnt !== model_cnt) begin
        errors++;
        $display("FAIL word_cnt: got %0d required %0d", word_cnt, model_cnt);
      end
      if (fifo_rd_en) begin
        checks++;
        if ((popped - delivered - ((m_valid && m_ready) ? 1 : 0)) >= 2) begin
          errors++;
          $display("FAIL rd_en_occupancy: issued with %0d words held, required < 2",
                   popped - delivered);
        end
      end
      if (flush) begin
        last_lost = popped - delivered;
        for (int i = 0; i < last_lost; i++) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        delivered = popped;
      end else if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL data_unexpected: got %0d required no word", m_data);
        end else begin
          e_data = exp_q.pop_front();
          if (m_data !== e_data) begin
            errors++;
            $display("FAIL data: got %0d required %0d", m_data, e_data);
          end
        end
        delivered++;
        model_cnt = model_cnt + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] v);
    wq.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("drain_left", exp_q.size(), 0);
  endtask

  int base_pop;

  initial begin
    // 1: reset state
    rd_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_word_cnt", word_cnt, 0);
    rd_rst_n = 1'b1;
    tick();

    // 2: streaming, first-word latency, back-to-back delivery
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) wr(DW'(100 + i));
    tick();
    chk("t2_lat_e0", m_valid, 0);
    tick();
    chk("t2_lat_e1", m_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", m_valid, 1);
      chk("t2_data", m_data, 100 + i);
      tick();
    end
    drain(20);
    chk("t2_word_cnt", word_cnt, 4);
    chk("t2_empty", fifo_empty, 1);

    // 3: back-pressure fills buffer to two and stops popping
    m_ready  = 1'b0;
    base_pop = popped;
    for (int i = 0; i < 4; i++) wr(DW'(100 + i));
    repeat (6) tick();
    chk("t3_pops", popped - base_pop, 2);
    chk("t3_rd_en", fifo_rd_en, 0);
    chk("t3_head", m_data, 100);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_nogap", m_valid, 1);
      tick();
    end
    drain(20);
    chk("t3_word_cnt", word_cnt, 8);

    // 4: alternating ready
    for (int i = 0; i < 8; i++) wr(DW'(200 + i));
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    drain(20);
    chk("t4_word_cnt", word_cnt, 16);

    // 5: flush with one word buffered and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(DW'(300 + i));
    repeat (3) tick();
    chk("t5_pre_valid", m_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_post_valid", m_valid, 0);
    chk("t5_lost", last_lost, 2);
    chk("t5_cnt_flush", word_cnt, 16);
    m_ready = 1'b1;
    drain(20);
    chk("t5_word_cnt", word_cnt, 18);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) wr(DW'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    drain(100);
    chk("rand_word_cnt", word_cnt, model_cnt);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) wr(DW'(400 + i));
    repeat (4) tick();
    #2;
    rd_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_data", m_data, 0);
    chk("t6_rst_rd_en", fifo_rd_en, 0);
    chk("t6_rst_cnt", word_cnt, 0);
    repeat (2) tick();
    rd_rst_n = 1'b1;
    tick();
    wr(16'd500);
    wr(16'd501);
    drain(20);
    chk("t6_word_cnt", word_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
